// File: rtl/jogo_sequencia_param.sv
// Simon-style memory game: LFSR-generated sequence, LED playback, key checking, optional play timeout.
// Latency: a keypress edge is judged two cycles later (ESPERA -> REGISTRA -> COMPARA); all outputs registered.
// Backpressure: none; keys are sampled every cycle and `iniciar` is honoured only in INICIAL or a final state.
// Optional feature macro: JOGO_TIMEOUT_EN (per-play timer and FIM_TIMEOUT state).
module jogo_sequencia_param #(
    parameter int         NUM_CHAVES  = 4,
    parameter int         PROF        = 16,
    parameter int         NIVEL_FACIL = 4,
    parameter int         T_MOSTRA    = 1000,
    parameter int         T_APAGA     = 250,
    parameter int         T_LIMITE    = 5000,
    parameter logic [7:0] SEMENTE     = 8'hB5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      sel_nivel,
    input  logic [NUM_CHAVES-1:0]     chaves,
    output logic                      pronto,
    output logic                      acertou,
    output logic                      errou,
    output logic                      timeout,
    output logic [NUM_CHAVES-1:0]     leds,
    output logic [3:0]                db_estado,
    output logic [$clog2(PROF)-1:0]   db_rodada,
    output logic [$clog2(PROF)-1:0]   db_endereco
);

    localparam int AW    = $clog2(PROF);
    localparam int KW    = $clog2(NUM_CHAVES);
    localparam int T_MX1 = (T_MOSTRA > T_APAGA) ? T_MOSTRA : T_APAGA;
    localparam int T_MAX = (T_MX1 > T_LIMITE) ? T_MX1 : T_LIMITE;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        APAGA       = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t               estado;
    logic [7:0]            lfsr;
    logic [7:0]            lfsr_prox;
    logic [NUM_CHAVES-1:0] elem_novo;
    logic [NUM_CHAVES-1:0] mem [PROF];
    logic [AW-1:0]         rodada;
    logic [AW-1:0]         endereco;
    logic [AW-1:0]         limite;
    logic [AW-1:0]         k;
    // Shared between playback timing and the per-play timer; they never run together.
    logic [CW-1:0]         cnt;
    logic [NUM_CHAVES-1:0] chaves_ant;
    logic [NUM_CHAVES-1:0] jogada;
    logic                  jogada_nova;

    assign lfsr_prox   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign elem_novo   = NUM_CHAVES'(1) << lfsr_prox[KW-1:0];
    assign jogada_nova = (chaves != '0) && (chaves_ant == '0);

    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_endereco = endereco;

`ifdef JOGO_TIMEOUT_EN
    logic timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (estado == PREPARA) begin
            mem[k] <= elem_novo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            lfsr       <= SEMENTE;
            rodada     <= '0;
            endereco   <= '0;
            limite     <= '0;
            k          <= '0;
            cnt        <= '0;
            chaves_ant <= '0;
            jogada     <= '0;
            leds       <= '0;
            pronto     <= 1'b0;
            acertou    <= 1'b0;
            errou      <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
            timeout_r  <= 1'b0;
`endif
        end else begin
            chaves_ant <= chaves;
            case (estado)
                INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        estado   <= PREPARA;
                        rodada   <= '0;
                        endereco <= '0;
                        k        <= '0;
                        cnt      <= '0;
                        leds     <= '0;
                        pronto   <= 1'b0;
                        acertou  <= 1'b0;
                        errou    <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
                        timeout_r <= 1'b0;
`endif
                        limite   <= sel_nivel ? AW'(PROF - 1) : AW'(NIVEL_FACIL - 1);
                    end
                end
                PREPARA: begin
                    lfsr <= lfsr_prox;
                    k    <= k + AW'(1);
                    if (k == AW'(PROF - 1)) begin
                        estado <= MOSTRA;
                        leds   <= mem[0];
                    end
                end
                MOSTRA: begin
                    if (cnt == CW'(T_MOSTRA - 1)) begin
                        cnt    <= '0;
                        leds   <= '0;
                        estado <= APAGA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                APAGA: begin
                    if (cnt == CW'(T_APAGA - 1)) begin
                        cnt <= '0;
                        if (endereco == rodada) begin
                            endereco <= '0;
                            leds     <= chaves;
                            estado   <= ESPERA;
                        end else begin
                            endereco <= endereco + AW'(1);
                            leds     <= mem[endereco + AW'(1)];
                            estado   <= MOSTRA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ESPERA: begin
                    leds <= chaves;
                    // A detected play beats a timer expiring in the same cycle.
                    if (jogada_nova) begin
                        cnt    <= '0;
                        estado <= REGISTRA;
                    end
`ifdef JOGO_TIMEOUT_EN
                    else if (cnt == CW'(T_LIMITE - 1)) begin
                        estado    <= FIM_TIMEOUT;
                        leds      <= '0;
                        pronto    <= 1'b1;
                        errou     <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                REGISTRA: begin
                    leds   <= chaves;
                    jogada <= chaves;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    leds <= chaves;
                    if (jogada != mem[endereco]) begin
                        estado <= FIM_ERRO;
                        leds   <= '0;
                        pronto <= 1'b1;
                        errou  <= 1'b1;
                    end else if (endereco != rodada) begin
                        estado <= PROX_JOGADA;
                    end else if (rodada == limite) begin
                        estado  <= FIM_ACERTO;
                        leds    <= '0;
                        pronto  <= 1'b1;
                        acertou <= 1'b1;
                    end else begin
                        estado <= PROX_RODADA;
                    end
                end
                PROX_JOGADA: begin
                    leds     <= chaves;
                    endereco <= endereco + AW'(1);
                    cnt      <= '0;
                    estado   <= ESPERA;
                end
                PROX_RODADA: begin
                    rodada   <= rodada + AW'(1);
                    endereco <= '0;
                    cnt      <= '0;
                    leds     <= mem[0];
                    estado   <= MOSTRA;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: table of first-play outcomes, full easy/hard games, timeout, key hold and reset.
// Finished-game outcomes go through a scoreboard queue filled when each game is started.
module tb_jogo_sequencia_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       sel_nivel;
    logic [3:0] chaves;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] leds;
    logic [3:0] db_estado;
    logic [2:0] db_rodada, db_endereco;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] estado;
        logic       pronto;
        logic       acertou;
        logic       errou;
        logic       timeout;
    } res_t;
    res_t sb[$];

    typedef struct {
        logic [3:0] tecla;
        logic [3:0] estado_esp;
        logic       errou_esp;
    } vetor_t;
    vetor_t tab[6];

    logic [7:0] lfsr_m;
    logic [3:0] seq_m [8];

    jogo_sequencia_param #(
        .NUM_CHAVES(4), .PROF(8), .NIVEL_FACIL(4), .T_MOSTRA(4),
        .T_APAGA(2), .T_LIMITE(20), .SEMENTE(8'hB5)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .sel_nivel(sel_nivel),
        .chaves(chaves), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .leds(leds), .db_estado(db_estado),
        .db_rodada(db_rodada), .db_endereco(db_endereco)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic gera_seq();
        for (int i = 0; i < 8; i++) begin
            lfsr_m    = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            seq_m[i]  = 4'b0001 << lfsr_m[1:0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; sel_nivel = 1'b0; chaves = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        lfsr_m = 8'hB5;
    endtask

    task automatic start(input logic nivel);
        sel_nivel = nivel;
        iniciar   = 1'b1;
        tick();
        iniciar   = 1'b0;
        gera_seq();
    endtask

    task automatic wait_estado(input logic [3:0] alvo, input string nome);
        int n = 0;
        while (db_estado !== alvo && n < 200) begin
            tick();
            n++;
        end
        check(nome, db_estado, alvo);
    endtask

    task automatic conta(input logic [3:0] code, input int limite, output int n,
                         output logic [3:0] l_or, output logic [3:0] l_and);
        n = 0; l_or = '0; l_and = '1;
        while (db_estado === code && n < limite) begin
            l_or  = l_or | leds;
            l_and = l_and & leds;
            tick();
            n++;
        end
    endtask

    task automatic mostra(input int r);
        int n;
        logic [3:0] lo, la;
        wait_estado(4'h2, "inicio_mostra");
        for (int e = 0; e <= r; e++) begin
            conta(4'h2, 100, n, lo, la);
            check("dur_mostra", n, 4);
            check("leds_mostra", {lo, la}, {seq_m[e], seq_m[e]});
            conta(4'h3, 100, n, lo, la);
            check("dur_apaga", n, 2);
            check("leds_apaga", lo, 4'b0000);
        end
        check("espera_apos_mostra", db_estado, 4'h4);
    endtask

    task automatic jogada(input logic [3:0] tecla);
        chaves = tecla;
        tick();
        tick();
        chaves = '0;
        tick();
    endtask

    task automatic jogadas(input int r, input int lim);
        for (int e = 0; e <= r; e++) begin
            jogada(seq_m[e]);
            if (e < r) begin
                check("prox_jogada", db_estado, 4'h7);
                tick();
            end else begin
                check("fim_rodada", db_estado, (r == lim) ? 4'hA : 4'h8);
            end
        end
    endtask

    task automatic fim_de_jogo();
        int   n = 0;
        res_t e;
        while (!pronto && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_vazio: got empty queue expected pending result");
        end else begin
            e = sb.pop_front();
            check("fim_estado", db_estado, e.estado);
            check("fim_pronto", pronto, e.pronto);
            check("fim_acertou", acertou, e.acertou);
            check("fim_errou", errou, e.errou);
            check("fim_timeout", timeout, e.timeout);
            check("fim_leds", leds, 4'b0000);
        end
    endtask

    initial begin
        int n;
        int nreg;
        logic [3:0] lo, la;

        tab[0] = '{4'b1000, 4'h8, 1'b0};
        tab[1] = '{4'b0100, 4'hE, 1'b1};
        tab[2] = '{4'b1001, 4'hE, 1'b1};
        tab[3] = '{4'b0001, 4'hE, 1'b1};
        tab[4] = '{4'b1111, 4'hE, 1'b1};
        tab[5] = '{4'b0010, 4'hE, 1'b1};

        // Reset state.
        do_reset();
        check("reset_saidas", {pronto, acertou, errou, timeout, leds, db_estado, db_rodada, db_endereco}, 0);

        // Easy game: first playback timing with literal first element, then full win.
        sb.push_back('{4'hA, 1'b1, 1'b1, 1'b0, 1'b0});
        start(1'b0);
        conta(4'h1, 100, n, lo, la);
        check("dur_prepara", n, 8);
        conta(4'h2, 100, n, lo, la);
        check("dur_mostra0", n, 4);
        check("leds_mostra0", {lo, la}, {4'b1000, 4'b1000});
        conta(4'h3, 100, n, lo, la);
        check("dur_apaga0", n, 2);
        check("leds_apaga0", lo, 4'b0000);
        check("espera0", db_estado, 4'h4);
        jogadas(0, 3);
        for (int r = 1; r <= 3; r++) begin
            mostra(r);
            jogadas(r, 3);
        end
        fim_de_jogo();
        check("rodada_final_facil", db_rodada, 3);

        // Hard game from a final state: fresh LFSR values, cleared outputs, eight rounds.
        sb.push_back('{4'hA, 1'b1, 1'b1, 1'b0, 1'b0});
        start(1'b1);
        check("restart_limpo", {pronto, acertou, errou, timeout, db_estado}, {4'b0000, 4'h1});
        mostra(0);
        check("novo_elem0", (leds == 4'b1000) ? 1 : 0, 0);
        jogadas(0, 7);
        for (int r = 1; r <= 7; r++) begin
            mostra(r);
            jogadas(r, 7);
        end
        fim_de_jogo();
        check("rodada_final_dificil", db_rodada, 7);

        // Table: first play of round 0 after reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start(1'b0);
            wait_estado(4'h4, "tab_espera");
            chaves = tab[i].tecla;
            tick();
            check("tab_registra", db_estado, 4'h5);
            tick();
            check("tab_compara", db_estado, 4'h6);
            chaves = '0;
            tick();
            check("tab_estado", db_estado, tab[i].estado_esp);
            check("tab_errou", errou, tab[i].errou_esp);
            check("tab_acertou_timeout", {acertou, timeout}, 2'b00);
        end

        // Timeout after a correct first play in round 1.
        do_reset();
`ifdef JOGO_TIMEOUT_EN
        sb.push_back('{4'hD, 1'b1, 1'b0, 1'b1, 1'b1});
`endif
        start(1'b0);
        mostra(0);
        jogadas(0, 3);
        mostra(1);
        jogada(seq_m[0]);
        check("to_prox_jogada", db_estado, 4'h7);
        tick();
`ifdef JOGO_TIMEOUT_EN
        conta(4'h4, 100, n, lo, la);
        check("to_dur_espera", n, 20);
        fim_de_jogo();
`else
        for (int i = 0; i < 40; i++) tick();
        check("sem_timeout_estado", db_estado, 4'h4);
        check("sem_timeout_saida", {pronto, errou, timeout}, 3'b000);
`endif

        // Held key registers one play; reset during playback clears everything at once.
        do_reset();
        start(1'b0);
        mostra(0);
        jogadas(0, 3);
        mostra(1);
        nreg   = 0;
        chaves = seq_m[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            if (db_estado === 4'h5) nreg++;
        end
        check("hold_uma_jogada", nreg, 1);
        check("hold_estado", db_estado, 4'h4);
        check("hold_endereco", db_endereco, 1);
        chaves = '0;
        tick();
        jogada(seq_m[1]);
        check("hold_prox_rodada", db_estado, 4'h8);
        wait_estado(4'h2, "mostra_antes_reset");
        tick();
        reset = 1'b1;
        #1;
        check("reset_async", {pronto, acertou, errou, timeout, leds, db_estado, db_rodada, db_endereco}, 0);
        tick();
        reset = 1'b0;
        tick();
        check("reset_estado", db_estado, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
Parametrised next-generation memory-game engine (Simon style), self-contained: it generates its own sequence, plays it back on LEDs, checks player keypresses, and handles timeout.
- Generalises the fixed 4-key, fixed-depth game to NUM_CHAVES keys, configurable depth, a configurable easy-level length and configurable display/timeout timing.
- Sits between the board keys/LEDs and the hexa7seg debug displays.

Parameters:
NUM_CHAVES, 4, number of keys/LEDs; power of two, 2..8
PROF, 16, sequence memory depth = hard-level round count; power of two
NIVEL_FACIL, 4, round count when sel_nivel=0; 1..PROF
T_MOSTRA, 1000, cycles each element is lit during playback
T_APAGA, 250, cycles dark between playback elements
T_LIMITE, 5000, cycles allowed per play before timeout
SEMENTE, 8'hB5, LFSR reset value; must be nonzero

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start pulse; level-sensed in INICIAL and final states
sel_nivel  in  1  0=easy (NIVEL_FACIL rounds), 1=hard (PROF rounds); sampled when a game starts
chaves  in  NUM_CHAVES  player keys, active high, synchronous to clock
pronto  out  1  game finished
acertou  out  1  game won
errou  out  1  game lost (wrong key or timeout)
timeout  out  1  loss was caused by timeout
leds  out  NUM_CHAVES  playback/echo LEDs
db_estado  out  4  state code
db_rodada  out  $clog2(PROF)  current round index
db_endereco  out  $clog2(PROF)  current element index

Behaviour:
- Reset: state INICIAL; all outputs 0; LFSR=SEMENTE; rodada=endereco=0; timers 0. Reset is effective mid-game from any state.
- LFSR: 8-bit, shift left, new LSB = b7^b5^b4^b3.
  - Each generation step advances the LFSR once, then stores onehot(lfsr mod NUM_CHAVES) into mem[k].
  - The LFSR is not reloaded between games, so successive games differ.
- States/codes:
  - INICIAL 0
  - PREPARA 1: fills mem[0..PROF-1], one per cycle, PROF cycles.
  - MOSTRA 2: leds=mem[endereco] for T_MOSTRA cycles.
  - APAGA 3: leds=0 for T_APAGA cycles; endereco++, or when endereco==rodada, endereco=0 and go to ESPERA.
  - ESPERA 4: leds=chaves.
  - REGISTRA 5: captures chaves into jogada register.
  - COMPARA 6
  - PROX_JOGADA 7: endereco++, back to ESPERA.
  - PROX_RODADA 8: rodada++, endereco=0, go to MOSTRA.
  - FIM_ACERTO A
  - FIM_ERRO E
  - FIM_TIMEOUT D
- Start: iniciar=1 in INICIAL or any FIM state moves to PREPARA.
  - Clears rodada, endereco, pronto, acertou, errou and timeout.
  - Latches limite = sel_nivel ? PROF-1 : NIVEL_FACIL-1.
  - iniciar is ignored in all other states.
- Play detection in ESPERA: a play is chaves!=0 while the previous-cycle chaves==0 (rising edge of any key). Holding keys never repeats a play.
  - Detect cycle: ESPERA→REGISTRA.
  - Next cycle: REGISTRA→COMPARA.
  - Next cycle: COMPARA decides.
- COMPARA decision:
  - jogada!=mem[endereco] (including multi-key) → FIM_ERRO.
  - Equal and endereco<rodada → PROX_JOGADA.
  - Equal, endereco==rodada and rodada==limite → FIM_ACERTO.
  - Otherwise → PROX_RODADA.
- Timer: runs only in ESPERA. It clears on entry to ESPERA and on every detected play. Reaching T_LIMITE-1 moves to FIM_TIMEOUT.
  - If a play is detected in the same cycle, the play wins.
- Final-state outputs, registered and held until the next start:
  - All final states: pronto=1, leds=0.
  - FIM_ACERTO: acertou=1.
  - FIM_ERRO: errou=1.
  - FIM_TIMEOUT: errou=1, timeout=1.
- Width: rodada, endereco and the timers must not wrap within legal parameter ranges. endereco never exceeds rodada.

Optional Feature:
JOGO_TIMEOUT_EN:
- Defined: timer and FIM_TIMEOUT implemented as described above.
- Undefined: no timer logic; ESPERA waits indefinitely; timeout output tied to 0; state D unreachable.

Test Plan:
Bench parameters for all scenarios: NUM_CHAVES=4, PROF=8, NIVEL_FACIL=4, T_MOSTRA=4, T_APAGA=2, T_LIMITE=20, SEMENTE=8'hB5. Expected sequence: 1000, 0100, 0001, 0010.
1. Reset, then iniciar with sel_nivel=0 → db_estado 1 for 8 cycles, then 2 with leds=4'b1000 for 4 cycles, then 3 with leds=0 for 2 cycles, then 4.
2. Correct plays each round, keys released between plays → playback lengths 1,2,3,4 → pronto=1, acertou=1, errou=0, db_estado=A, db_rodada=3.
3. Round 0: press 4'b0100 → COMPARA 2 cycles after the edge → FIM_ERRO: errou=1, acertou=0, timeout=0, db_estado=E. Same result for multi-key 4'b1001.
4. Round 1: correct first play, then idle 20 cycles → db_estado=D, errou=1, timeout=1. With JOGO_TIMEOUT_EN undefined, state stays 4.
5. Hold 4'b1000 across 10 cycles in round 1 → exactly one play registered. Assert reset during MOSTRA → all outputs 0 and db_estado 0 immediately.
6. After a finish, iniciar with sel_nivel=1 → mem refilled with fresh LFSR values (first element ≠ 4'b1000 for this seed), outputs cleared, limite=7.
